// File: rtl/cr_tlvp_axis_nch_arb.sv
// N-channel AXI4-stream ingress: per-channel FIFOs merged onto one registered outbound stream.
// Arbitration is per frame (round-robin or strict priority); tid carries the source channel.
module cr_tlvp_axis_nch_arb #(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 64,
    parameter int USER_W      = 8,
    parameter int N_ENTRIES   = 16,
    parameter int N_AFULL_VAL = 3,
    parameter int ARB_MODE    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          ib_tvalid,
    output logic [N_CH-1:0]          ib_tready,
    input  logic [N_CH*DATA_W-1:0]   ib_tdata,
    input  logic [N_CH*USER_W-1:0]   ib_tuser,
    input  logic [N_CH-1:0]          ib_tlast,
    input  logic [N_CH-1:0]          ch_enable,
    output logic                     ob_tvalid,
    input  logic                     ob_tready,
    output logic [DATA_W-1:0]        ob_tdata,
    output logic [USER_W-1:0]        ob_tuser,
    output logic                     ob_tlast,
    output logic [$clog2(N_CH)-1:0]  ob_tid,
    output logic [N_CH-1:0]          ch_empty,
    output logic [N_CH-1:0]          ch_afull,
    output logic [31:0]              ob_frame_cnt
);

    localparam int TID_W    = $clog2(N_CH);
    localparam int PTR_W    = $clog2(N_ENTRIES);
    localparam int CNT_W    = PTR_W + 1;
    localparam int ENT_W    = DATA_W + USER_W + 1;
    localparam int AFULL_TH = N_ENTRIES - N_AFULL_VAL;

    typedef enum logic {S_IDLE, S_LOCKED} state_e;

    logic [ENT_W-1:0]  mem_q [N_CH][N_ENTRIES];
    logic [PTR_W-1:0]  wr_ptr_q [N_CH];
    logic [PTR_W-1:0]  wr_ptr_d [N_CH];
    logic [PTR_W-1:0]  rd_ptr_q [N_CH];
    logic [PTR_W-1:0]  rd_ptr_d [N_CH];
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [N_CH-1:0]   empty_q, empty_d;
    logic [N_CH-1:0]   afull_q, afull_d;
    logic [N_CH-1:0]   full_q, full_d;
    logic [N_CH-1:0]   push, pop;
    logic [N_CH-1:0]   cand;
    logic              pop_any;
    logic [ENT_W-1:0]  pop_entry;
    logic [TID_W-1:0]  pick;
    logic              found;

    state_e            state_q, state_d;
    logic [TID_W-1:0]  gnt_q, gnt_d;
    logic [TID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              ob_tvalid_q, ob_tvalid_d;
    logic [DATA_W-1:0] ob_tdata_q, ob_tdata_d;
    logic [USER_W-1:0] ob_tuser_q, ob_tuser_d;
    logic              ob_tlast_q, ob_tlast_d;
    logic [TID_W-1:0]  ob_tid_q, ob_tid_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a beat while draining.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
        pop = '0;
        if (state_q == S_LOCKED && !empty_q[gnt_q] && (!ob_tvalid_q || ob_tready)) begin
            pop[gnt_q] = 1'b1;
        end
        pop_any   = |pop;
        pop_entry = mem_q[gnt_q][rd_ptr_q[gnt_q]];
        ib_tready = ~full_q | pop;
        push      = ib_tvalid & ib_tready;
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            empty_d[i]  = (cnt_d[i] == '0);
            afull_d[i]  = (cnt_d[i] >= CNT_W'(AFULL_TH));
            full_d[i]   = (cnt_d[i] == CNT_W'(N_ENTRIES));
        end
    end

    // NOTE: the storage array is not reset; validity is tracked by the pointers and counts alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {ib_tlast[i], ib_tuser[i*USER_W +: USER_W],
                                          ib_tdata[i*DATA_W +: DATA_W]};
            end
        end
    end

    // Round-robin scans from the channel after the last frame's owner; priority scans from 0.
    always_comb begin
        cand  = ~empty_q & ch_enable;
        pick  = '0;
        found = 1'b0;
        if (ARB_MODE == 1) begin
            for (int j = 0; j < N_CH; j++) begin
                if (!found && cand[j]) begin
                    pick  = TID_W'(j);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                for (int j = 0; j < N_CH; j++) begin
                    if (!found && cand[j] && j == (int'(rr_ptr_q) + k) % N_CH) begin
                        pick  = TID_W'(j);
                        found = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (pop_any && pop_entry[ENT_W-1]) begin
                    state_d = S_IDLE;
                    if (ARB_MODE == 0) begin
                        rr_ptr_d = gnt_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ob_tvalid_d = ob_tvalid_q;
        ob_tdata_d  = ob_tdata_q;
        ob_tuser_d  = ob_tuser_q;
        ob_tlast_d  = ob_tlast_q;
        ob_tid_d    = ob_tid_q;
        if (pop_any) begin
            ob_tvalid_d = 1'b1;
            ob_tdata_d  = pop_entry[DATA_W-1:0];
            ob_tuser_d  = pop_entry[DATA_W +: USER_W];
            ob_tlast_d  = pop_entry[ENT_W-1];
            ob_tid_d    = gnt_q;
        end else if (ob_tready) begin
            ob_tvalid_d = 1'b0;
        end
        frame_cnt_d = frame_cnt_q + 32'(ob_tvalid_q & ob_tready & ob_tlast_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            empty_q     <= '1;
            afull_q     <= '0;
            full_q      <= '0;
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= TID_W'(N_CH - 1);
            ob_tvalid_q <= 1'b0;
            ob_tdata_q  <= '0;
            ob_tuser_q  <= '0;
            ob_tlast_q  <= 1'b0;
            ob_tid_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            full_q      <= full_d;
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            ob_tvalid_q <= ob_tvalid_d;
            ob_tdata_q  <= ob_tdata_d;
            ob_tuser_q  <= ob_tuser_d;
            ob_tlast_q  <= ob_tlast_d;
            ob_tid_q    <= ob_tid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ob_tvalid    = ob_tvalid_q;
    assign ob_tdata     = ob_tdata_q;
    assign ob_tuser     = ob_tuser_q;
    assign ob_tlast     = ob_tlast_q;
    assign ob_tid       = ob_tid_q;
    assign ch_empty     = empty_q;
    assign ch_afull     = afull_q;
    assign ob_frame_cnt = frame_cnt_q;

endmodule
